// File: rtl/burst_rule_checker.sv
// burst_rule_checker: per-channel monitor for the burst-termination idle rule
module burst_rule_checker #(
  parameter int NUM_CH  = 1,
  parameter int DELAY   = 2,
  parameter int RUN_LEN = 7,
  parameter int MODE    = 0,
  parameter int WIN     = 16,
  parameter int CNT_W   = 16
) (
  input  logic              mclk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] burst_mode,
  input  logic [NUM_CH-1:0] irdy,
  input  logic [NUM_CH-1:0] trdy,
  output logic [NUM_CH-1:0] busy,
  output logic [NUM_CH-1:0] pass,
  output logic [NUM_CH-1:0] fail,
  output logic [CNT_W-1:0]  pass_cnt,
  output logic [CNT_W-1:0]  fail_cnt
);
  typedef enum logic [1:0] {IDLE, WAIT, RUN} state_t;
  localparam logic [7:0] DLY_M1 = 8'(DELAY > 0 ? DELAY - 1 : 0);
  localparam logic [7:0] RLEN = 8'(RUN_LEN);
  localparam logic [7:0] WLEN = 8'(WIN);
  localparam int SUM_W = CNT_W + $clog2(NUM_CH + 1);
  localparam logic [SUM_W-1:0] SAT = SUM_W'({CNT_W{1'b1}});
  logic [NUM_CH-1:0] r_bm_q, r_pass, r_fail, w_pass, w_fail;
  logic [CNT_W-1:0] r_pass_cnt, r_fail_cnt;
  logic [SUM_W-1:0] w_psum, w_fsum;
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    state_t r_state, w_state;
    logic [7:0] r_dcnt, r_rcnt, r_wcnt, w_dcnt, w_rcnt, w_wcnt, w_r1, w_w1;
    logic w_fell, w_idle, w_chk, w_p, w_f;
    assign w_fell = r_bm_q[c] & ~burst_mode[c];
    assign w_idle = ~irdy[c] & ~trdy[c];
    // the last WAIT cycle and, with no delay, the fell cycle itself are check cycles too
    assign w_chk = (r_state == RUN) || (r_state == WAIT && r_dcnt == 8'd0) ||
                   (r_state == IDLE && w_fell && DELAY == 0);
    assign w_r1 = (r_state == RUN ? r_rcnt : 8'd0) + (MODE == 0 ? 8'd1 : {7'd0, w_idle});
    assign w_w1 = (r_state == RUN ? r_wcnt : 8'd0) + 8'd1;
    assign w_pass[c] = w_p;
    assign w_fail[c] = w_f;
    assign busy[c] = (r_state != IDLE) | r_pass[c] | r_fail[c];
    // next state and the pass/fail decision for this cycle
    always_comb begin
      w_state = r_state;
      w_dcnt = r_dcnt;
      w_rcnt = r_rcnt;
      w_wcnt = r_wcnt;
      w_p = 1'b0;
      w_f = 1'b0;
      if (r_state == IDLE && w_fell && DELAY > 0) begin
        w_state = WAIT;
        w_dcnt = DLY_M1;
      end else if (r_state != IDLE && burst_mode[c]) begin
        w_state = IDLE;
        w_f = 1'b1;
      end else if (w_chk) begin
        if (MODE == 0 && !w_idle) begin
          w_state = IDLE;
          w_f = 1'b1;
        end else if (w_r1 == RLEN) begin
          w_state = IDLE;
          w_p = 1'b1;
        end else if (MODE != 0 && w_w1 == WLEN) begin
          w_state = IDLE;
          w_f = 1'b1;
        end else begin
          w_state = RUN;
          w_rcnt = w_r1;
          w_wcnt = w_w1;
        end
      end else if (r_state == WAIT) begin
        w_dcnt = r_dcnt - 8'd1;
      end
    end
    // channel state register
    always_ff @(posedge mclk) begin
      if (rst) begin
        r_state <= IDLE;
        r_dcnt <= '0;
        r_rcnt <= '0;
        r_wcnt <= '0;
      end else begin
        r_state <= w_state;
        r_dcnt <= w_dcnt;
        r_rcnt <= w_rcnt;
        r_wcnt <= w_wcnt;
      end
    end
  end
  assign w_psum = SUM_W'(r_pass_cnt) + SUM_W'($countones(w_pass));
  assign w_fsum = SUM_W'(r_fail_cnt) + SUM_W'($countones(w_fail));
  assign pass = r_pass;
  assign fail = r_fail;
  assign pass_cnt = r_pass_cnt;
  assign fail_cnt = r_fail_cnt;
  // edge history, registered pulses and saturating totals that track the pulses
  always_ff @(posedge mclk) begin
    if (rst) begin
      r_bm_q <= '0;
      r_pass <= '0;
      r_fail <= '0;
      r_pass_cnt <= '0;
      r_fail_cnt <= '0;
    end else begin
      r_bm_q <= burst_mode;
      r_pass <= w_pass;
      r_fail <= w_fail;
      r_pass_cnt <= w_psum > SAT ? '1 : w_psum[CNT_W-1:0];
      r_fail_cnt <= w_fsum > SAT ? '1 : w_fsum[CNT_W-1:0];
    end
  end
endmodule

// File: tb/tb_burst_rule_checker.sv
// tb_burst_rule_checker: directed tables plus randomized traces against a lookahead rule model
module tb_burst_rule_checker;
  logic mclk = 1'b0;
  logic rst = 1'b0;
  always #5 mclk = ~mclk;
  logic [1:0] bm0 = '0, ir0 = '0, tr0 = '0, busy0, pass0, fail0;
  logic [1:0] bm1 = '0, ir1 = '0, tr1 = '0, busy1, pass1, fail1;
  logic [3:0] bm2 = '0, ir2 = '0, tr2 = '0, busy2, pass2, fail2;
  logic [15:0] pc0, fc0, pc1, fc1;
  logic [1:0] pc2, fc2;
  burst_rule_checker #(.NUM_CH(2)) u_d0 (.mclk(mclk), .rst(rst), .burst_mode(bm0), .irdy(ir0), .trdy(tr0),
    .busy(busy0), .pass(pass0), .fail(fail0), .pass_cnt(pc0), .fail_cnt(fc0));
  burst_rule_checker #(.NUM_CH(2), .DELAY(0), .RUN_LEN(3), .MODE(1), .WIN(5)) u_d1 (.mclk(mclk), .rst(rst),
    .burst_mode(bm1), .irdy(ir1), .trdy(tr1), .busy(busy1), .pass(pass1), .fail(fail1), .pass_cnt(pc1), .fail_cnt(fc1));
  burst_rule_checker #(.NUM_CH(4), .CNT_W(2)) u_d2 (.mclk(mclk), .rst(rst), .burst_mode(bm2), .irdy(ir2), .trdy(tr2),
    .busy(busy2), .pass(pass2), .fail(fail2), .pass_cnt(pc2), .fail_cnt(fc2));

  int n_tests = 0, n_fail = 0;
  typedef struct {
    int dut; int cyc; bit rst; bit chk;
    logic bm; logic ir; logic tr;
    logic e_busy; logic e_pass; logic e_fail; int e_pc; int e_fc;
  } vec_t;
  vec_t vq[$];

  localparam int N = 300;
  localparam int L = N + 40;
  bit rb[2][2][L], ri[2][2][L], ep[2][2][L], ef[2][2][L], eb[2][2][L];
  logic [1:0] rnz[2][2][L];

  task automatic chk(string name, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add(int d, int c, bit r, bit k, logic b, logic i, logic t,
                     logic eb_, logic ep_, logic ef_, int epc, int efc);
    vec_t v;
    v.dut = d; v.cyc = c; v.rst = r; v.chk = k; v.bm = b; v.ir = i; v.tr = t;
    v.e_busy = eb_; v.e_pass = ep_; v.e_fail = ef_; v.e_pc = epc; v.e_fc = efc;
    vq.push_back(v);
  endtask

  task automatic drive(int d, bit r, logic b, logic i, logic t);
    rst = r;
    bm0 = '0; ir0 = '0; tr0 = '0; bm1 = '0; ir1 = '0; tr1 = '0; bm2 = '0; ir2 = '0; tr2 = '0;
    if (d == 0) begin bm0[0] = b; ir0[0] = i; tr0[0] = t; end
    else if (d == 1) begin bm1[0] = b; ir1[0] = i; tr1[0] = t; end
    else begin bm2 = {4{b}}; ir2 = {4{i}}; tr2 = {4{t}}; end
  endtask

  function automatic int ev(int d, logic e);
    return d == 2 ? (e ? 15 : 0) : (e ? 1 : 0);
  endfunction

  // outcome of every rule instance, found by scanning forward from each accepted fell
  task automatic model(int d, int dly, int rl, int md, int win);
    for (int c = 0; c < 2; c++) begin
      int last;
      last = -1;
      for (int n = 0; n < L; n++) begin ep[d][c][n] = 0; ef[d][c][n] = 0; eb[d][c][n] = 0; end
      for (int t = 1; t < L; t++) begin
        if (rb[d][c][t-1] && !rb[d][c][t] && t > last) begin
          int cnt, w, k;
          bit ok;
          cnt = 0; w = 0; ok = 0;
          for (k = t; k < L - 1; k++) begin
            if (k > t && rb[d][c][k]) begin ok = 0; break; end
            if (k >= t + dly) begin
              if (md == 0 && !ri[d][c][k]) begin ok = 0; break; end
              cnt += int'(ri[d][c][k]);
              w++;
              if (cnt == rl) begin ok = 1; break; end
              if (md == 1 && w == win) begin ok = 0; break; end
            end
          end
          if (ok) ep[d][c][k+1] = 1; else ef[d][c][k+1] = 1;
          for (int j = t + 1; j <= k + 1; j++) eb[d][c][j] = 1;
          last = k;
        end
      end
    end
  endtask

  initial begin
    // A: clean pass, defaults
    add(0, -1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int c = 0; c <= 22; c++)
      add(0, c, 0, 1, c < 10, !(c >= 12 && c <= 18), 0, c >= 11 && c <= 19, c == 19, 0, c >= 19 ? 1 : 0, 0);
    // B: trdy at 15 breaks the run, then a new fell at 20 is accepted
    add(0, -1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int c = 0; c <= 22; c++)
      add(0, c, 0, 1, c < 10 || c == 19, !(c >= 12 && c <= 18), c == 15,
          (c >= 11 && c <= 16) || c >= 21, 0, c == 16, 0, c >= 16 ? 1 : 0);
    // C: burst_mode rises on the last check cycle
    add(0, -1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int c = 0; c <= 22; c++)
      add(0, c, 0, 1, c < 10 || c >= 18, !(c >= 12 && c <= 18), 0, c >= 11 && c <= 19, 0, c == 19, 0, c >= 19 ? 1 : 0);
    // D: window mode, idle at 4,6,8 passes
    add(1, -1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int c = 0; c <= 12; c++)
      add(1, c, 0, 1, c < 4, !(c == 4 || c == 6 || c == 8), 0, c >= 5 && c <= 9, c == 9, 0, c >= 9 ? 1 : 0, 0);
    // E: window mode, idle only at 4,6 expires the window
    add(1, -1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int c = 0; c <= 12; c++)
      add(1, c, 0, 1, c < 4, !(c == 4 || c == 6), 0, c >= 5 && c <= 9, 0, c == 9, 0, c >= 9 ? 1 : 0);
    // F: one pass, then reset in the middle of a second run
    add(0, -1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int c = 0; c <= 36; c++)
      add(0, c, c == 26, 1, c < 10 || c == 20 || c == 21, !((c >= 12 && c <= 18) || c >= 24), 0,
          (c >= 11 && c <= 19) || (c >= 23 && c <= 26), c == 19, 0, (c >= 19 && c <= 26) ? 1 : 0, 0);
    // G: four channels pass together into a 2-bit counter, then pass again
    add(2, -1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int c = 0; c <= 32; c++)
      add(2, c, 0, 1, c < 10 || c == 20, !((c >= 12 && c <= 18) || (c >= 23 && c <= 29)), 0,
          (c >= 11 && c <= 19) || (c >= 22 && c <= 30), c == 19 || c == 30, 0, c >= 19 ? 3 : 0, 0);

    foreach (vq[i]) begin
      vec_t v;
      int ab, ap, af, apc, afc;
      v = vq[i];
      @(negedge mclk);
      if (v.chk) begin
        if (v.dut == 0) begin ab = busy0; ap = pass0; af = fail0; apc = pc0; afc = fc0; end
        else if (v.dut == 1) begin ab = busy1; ap = pass1; af = fail1; apc = pc1; afc = fc1; end
        else begin ab = busy2; ap = pass2; af = fail2; apc = pc2; afc = fc2; end
        chk($sformatf("busy d%0d c%0d", v.dut, v.cyc), ab, ev(v.dut, v.e_busy));
        chk($sformatf("pass d%0d c%0d", v.dut, v.cyc), ap, ev(v.dut, v.e_pass));
        chk($sformatf("fail d%0d c%0d", v.dut, v.cyc), af, ev(v.dut, v.e_fail));
        chk($sformatf("pass_cnt d%0d c%0d", v.dut, v.cyc), apc, v.e_pc);
        chk($sformatf("fail_cnt d%0d c%0d", v.dut, v.cyc), afc, v.e_fc);
      end
      drive(v.dut, v.rst, v.bm, v.ir, v.tr);
    end

    // randomized traces on both 2-channel instances
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < 2; c++)
        for (int n = 0; n < L; n++) begin
          if (n >= N) begin rb[d][c][n] = 0; ri[d][c][n] = 1; end
          else begin
            rb[d][c][n] = n == 0 ? 1'b1 : ($urandom_range(0, 7) == 0 ? !rb[d][c][n-1] : rb[d][c][n-1]);
            ri[d][c][n] = $urandom_range(0, 7) != 0;
          end
          rnz[d][c][n] = 2'($urandom_range(1, 3));
        end
    model(0, 2, 7, 0, 16);
    model(1, 0, 3, 1, 5);
    @(negedge mclk);
    drive(0, 1, 0, 0, 0);
    begin
      int cpc[2], cfc[2];
      cpc = '{0, 0}; cfc = '{0, 0};
      for (int n = 0; n < L; n++) begin
        @(negedge mclk);
        for (int d = 0; d < 2; d++) begin
          int ab, ap, af, apc, afc;
          cpc[d] += int'(ep[d][0][n]) + int'(ep[d][1][n]);
          cfc[d] += int'(ef[d][0][n]) + int'(ef[d][1][n]);
          if (d == 0) begin ab = busy0; ap = pass0; af = fail0; apc = pc0; afc = fc0; end
          else begin ab = busy1; ap = pass1; af = fail1; apc = pc1; afc = fc1; end
          chk($sformatf("rnd busy d%0d n%0d", d, n), ab, {eb[d][1][n], eb[d][0][n]});
          chk($sformatf("rnd pass d%0d n%0d", d, n), ap, {ep[d][1][n], ep[d][0][n]});
          chk($sformatf("rnd fail d%0d n%0d", d, n), af, {ef[d][1][n], ef[d][0][n]});
          chk($sformatf("rnd pass_cnt d%0d n%0d", d, n), apc, cpc[d]);
          chk($sformatf("rnd fail_cnt d%0d n%0d", d, n), afc, cfc[d]);
        end
        rst = 1'b0;
        for (int c = 0; c < 2; c++) begin
          bm0[c] = rb[0][c][n];
          ir0[c] = ri[0][c][n] ? 1'b0 : rnz[0][c][n][0];
          tr0[c] = ri[0][c][n] ? 1'b0 : rnz[0][c][n][1];
          bm1[c] = rb[1][c][n];
          ir1[c] = ri[1][c][n] ? 1'b0 : rnz[1][c][n][0];
          tr1[c] = ri[1][c][n] ? 1'b0 : rnz[1][c][n][1];
        end
      end
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/burst_rule_checker.md
Name: burst_rule_checker

Overview:
- Synthesizable, multi-channel RTL monitor for the bus burst-termination rule.
- Rule: after a falling edge of burst_mode, and while burst_mode stays low, the bus goes idle (irdy==0 && trdy==0) for RUN_LEN cycles, starting DELAY cycles after the edge.
- Generalises the fixed 2-cycle delay / 7-cycle consecutive rule to parametrised delay, length and channel count, and adds a non-consecutive window mode.
- Per-channel pass/fail pulses and aggregate saturating counters feed the bench scoreboard and the on-chip debug status.

Parameters:
- NUM_CH, 1, number of independent channels.
- DELAY, 2, cycles from the fell cycle to the first idle-check cycle; range 0..255.
- RUN_LEN, 7, idle cycles required; range 1..255.
- MODE, 0, 0 = consecutive idle ([*RUN_LEN]); 1 = non-consecutive idle within a window ([=RUN_LEN]).
- WIN, 16, MODE 1 only: check-window length in cycles; WIN >= RUN_LEN.
- CNT_W, 16, width of the pass/fail counters.

Ports:
- mclk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- burst_mode  in  NUM_CH  per-channel burst mode.
- irdy  in  NUM_CH  per-channel initiator ready.
- trdy  in  NUM_CH  per-channel target ready.
- busy  out  NUM_CH  channel is evaluating a rule instance.
- pass  out  NUM_CH  1-cycle pulse: rule satisfied.
- fail  out  NUM_CH  1-cycle pulse: rule violated.
- pass_cnt  out  CNT_W  total passes, saturating.
- fail_cnt  out  CNT_W  total fails, saturating.

Behaviour:
- Reset (rst high at a posedge): all channels go to IDLE; bm_q, busy, pass, fail = 0; pass_cnt, fail_cnt = 0. Because bm_q resets to 0, no fell is detected on the first cycle after reset.
- Reset mid-evaluation aborts the instance silently: no pass or fail is produced.
- Fell detection (per channel): fell = bm_q & ~burst_mode, where bm_q is burst_mode registered one cycle. Call the fell cycle t.
- Per-channel FSM states: IDLE, WAIT, RUN. Counters: dcnt (8-bit), rcnt (8-bit), wcnt (8-bit).
- IDLE:
  - On fell with DELAY > 0: go to WAIT, dcnt = DELAY-1.
  - On fell with DELAY == 0: the fell cycle t is itself the first check cycle and is evaluated as a RUN cycle.
- WAIT:
  - burst_mode high: fail, go to IDLE.
  - Otherwise, when dcnt == 0: go to RUN. Otherwise decrement dcnt.
  - The first check cycle is t+DELAY.
- RUN, MODE 0 (consecutive), evaluated on each check cycle:
  - burst_mode high, or idle == 0: fail, go to IDLE.
  - Otherwise increment rcnt; when it reaches RUN_LEN: pass, go to IDLE.
  - The last check cycle is t+DELAY+RUN_LEN-1.
- RUN, MODE 1 (non-consecutive), evaluated on each check cycle:
  - burst_mode high: fail, go to IDLE.
  - Otherwise count idle cycles in rcnt and window cycles in wcnt.
  - rcnt reaches RUN_LEN: pass, go to IDLE.
  - wcnt reaches WIN with rcnt < RUN_LEN: fail, go to IDLE.
- throughout semantics: burst_mode is checked on every cycle from t+1 through the final check cycle inclusive. A burst_mode rise on the final cycle gives fail, not pass.
- Output timing: pass/fail are registered and assert exactly one cycle after the deciding cycle. Example with defaults: pass at t+9.
- busy is high from t+1 until the cycle pass/fail asserts, then low. pass and fail are never both high on one channel.
- Retrigger: a new fell cannot occur while busy, because any rise already caused fail. On the cycle fail asserts, a fell in that same cycle starts a new instance.
- Counters:
  - On each cycle, pass_cnt += popcount(pass) and fail_cnt += popcount(fail).
  - Saturate at 2^CNT_W-1; never wrap.
  - Counters update in the same cycle the pulses are high.
- Channels are fully independent; there is no cross-channel arbitration.

Test Plan:
- Defaults; burst_mode 1→0 at cycle 10; irdy=trdy=0 for cycles 12..18, burst_mode held low → pass[0] at cycle 19 only; pass_cnt=1; busy high cycles 11..19.
- Defaults; same as above but trdy=1 at cycle 15 → fail at 16; no pass; fail_cnt=1; channel accepts a new fell at 20.
- Defaults; burst_mode rises at cycle 18 (the last check cycle) → fail at 19, not pass.
- MODE=1, RUN_LEN=3, WIN=5, DELAY=0; fell at cycle 4; idle at cycles 4, 6, 8 → pass at 9. Variant with idle only at 4 and 6 → fail at 9 (window expired).
- NUM_CH=4, CNT_W=2: all channels pass in the same cycle → pass_cnt=3 (saturated). A further pass leaves pass_cnt=3.
- rst asserted at cycle 14 mid-RUN → next cycle busy=0, counters=0, no pass/fail; burst_mode held low after reset produces no fell.
